// File: rtl/rv64g_pkg.sv
// Shared rv64g pipeline types: decoder output, fetch entries and decode-stage state.
package rv64g_pkg;

  localparam int unsigned RV_XLEN = 64;

  // INVALID is the all-zero encoding so a zeroed command reads as illegal.
  typedef enum logic [4:0] {
    INVALID = 5'd0,
    LUI,
    AUIPC,
    JAL,
    JALR,
    BEQ,
    BNE,
    BLT,
    BGE,
    BLTU,
    BGEU,
    ADDI
  } funct_e;

  typedef struct packed {
    funct_e               funct;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [RV_XLEN-1:0]   imm;
  } decoded_instr_t;

  typedef struct packed {
    logic [RV_XLEN-1:0] pc;
    logic [31:0]        code;
  } fetch_entry_t;

  typedef enum logic {
    RUN,
    HALT
  } dec_state_e;

endpackage

// File: rtl/decode_fifo.sv
// Small power-of-two FIFO of fetch entries with synchronous flush.
module decode_fifo
  import rv64g_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         arst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t din_i,
  input  logic         pop_i,
  output fetch_entry_t dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count == (AW+1)'(DEPTH));
  assign empty_o = (count == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem[wr_ptr] <= din_i;
  end

endmodule

// File: rtl/instruction_decoder.sv
// Combinational decoder for the supported rv64g subset; anything else yields an all-zero (INVALID) command.
module instruction_decoder
  import rv64g_pkg::*;
(
  input  logic [31:0]    code_i,
  output decoded_instr_t cmd_o
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [4:0] rd;
  funct_e     funct;

  assign opcode = code_i[6:0];
  assign f3     = code_i[14:12];
  assign rd     = code_i[11:7];

  always_comb begin
    funct = INVALID;
    case (opcode)
      7'h37: funct = LUI;
      7'h17: funct = AUIPC;
      7'h6F: if (rd == 5'd0 || rd == 5'd1) funct = JAL;
      7'h67: if (f3 == 3'd0) funct = JALR;
      7'h13: if (f3 == 3'd0) funct = ADDI;
      7'h63: begin
        case (f3)
          3'd0:    funct = BEQ;
          3'd1:    funct = BNE;
          3'd4:    funct = BLT;
          3'd5:    funct = BGE;
          3'd6:    funct = BLTU;
          3'd7:    funct = BGEU;
          default: funct = INVALID;
        endcase
      end
      default: funct = INVALID;
    endcase
  end

  // Operand fields stay zero for INVALID so the whole command is '0.
  always_comb begin
    cmd_o       = '0;
    cmd_o.funct = funct;
    case (funct)
      LUI, AUIPC: begin
        cmd_o.rd  = rd;
        cmd_o.imm = {{32{code_i[31]}}, code_i[31:12], 12'b0};
      end
      JAL: begin
        cmd_o.rd  = rd;
        cmd_o.imm = {{43{code_i[31]}}, code_i[31], code_i[19:12], code_i[20], code_i[30:21], 1'b0};
      end
      JALR, ADDI: begin
        cmd_o.rd  = rd;
        cmd_o.rs1 = code_i[19:15];
        cmd_o.imm = {{52{code_i[31]}}, code_i[31:20]};
      end
      BEQ, BNE, BLT, BGE, BLTU, BGEU: begin
        cmd_o.rs1 = code_i[19:15];
        cmd_o.rs2 = code_i[24:20];
        cmd_o.imm = {{51{code_i[31]}}, code_i[31], code_i[7], code_i[30:25], code_i[11:8], 1'b0};
      end
      default: cmd_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage_ctrl.sv
// Decode-stage sequencer: buffers fetched entries, decodes the head and registers it toward issue; halts on illegal code.
module decode_stage_ctrl
  import rv64g_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic           clk_i,
  input  logic           arst_i,
  input  logic           flush_i,
  input  logic [XLEN-1:0] fetch_pc_i,
  input  logic [31:0]    fetch_code_i,
  input  logic           fetch_valid_i,
  output logic           fetch_ready_o,
  output decoded_instr_t dec_cmd_o,
  output logic [XLEN-1:0] dec_pc_o,
  output logic           dec_illegal_o,
  output logic           dec_valid_o,
  input  logic           dec_ready_i,
  output logic [XLEN-1:0] dec_count_o,
  output logic           halted_o
);

  dec_state_e     state;
  logic           accept_en;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           load;
  logic           head_illegal;
  fetch_entry_t   push_entry;
  fetch_entry_t   head;
  decoded_instr_t head_cmd;

  // accept_en keeps ready low until the first edge after reset release.
  assign fetch_ready_o = accept_en && !fifo_full && (state == RUN) && !flush_i;
  assign push          = fetch_valid_i && fetch_ready_o;
  assign load          = !fifo_empty && (state == RUN) && (!dec_valid_o || dec_ready_i) && !flush_i;
  assign head_illegal  = (head_cmd.funct == INVALID);
  assign halted_o      = (state == HALT);
  assign push_entry    = '{pc: RV_XLEN'(fetch_pc_i), code: fetch_code_i};

  decode_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .din_i   (push_entry),
    .pop_i   (load),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  instruction_decoder u_decoder (
    .code_i (head.code),
    .cmd_o  (head_cmd)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state         <= RUN;
      accept_en     <= 1'b0;
      dec_valid_o   <= 1'b0;
      dec_cmd_o     <= '0;
      dec_pc_o      <= '0;
      dec_illegal_o <= 1'b0;
      dec_count_o   <= '0;
    end else begin
      accept_en <= 1'b1;
      if (flush_i) begin
        state         <= RUN;
        dec_valid_o   <= 1'b0;
        dec_illegal_o <= 1'b0;
        dec_cmd_o     <= '0;
      end else begin
        if (dec_valid_o && dec_ready_i) dec_count_o <= dec_count_o + XLEN'(1);
        if (load) begin
          dec_valid_o   <= 1'b1;
          dec_cmd_o     <= head_cmd;
          dec_pc_o      <= XLEN'(head.pc);
          dec_illegal_o <= head_illegal;
          if (head_illegal) state <= HALT;
        end else if (dec_valid_o && dec_ready_i) begin
          dec_valid_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Self-checking bench for decode_stage_ctrl: directed scenarios plus randomized traffic against an in-order scoreboard.
module tb_decode_stage_ctrl;
  import rv64g_pkg::*;

  logic           clk_i = 1'b0;
  logic           arst_i;
  logic           flush_i;
  logic [63:0]    fetch_pc_i;
  logic [31:0]    fetch_code_i;
  logic           fetch_valid_i;
  logic           fetch_ready_o;
  decoded_instr_t dec_cmd_o;
  logic [63:0]    dec_pc_o;
  logic           dec_illegal_o;
  logic           dec_valid_o;
  logic           dec_ready_i;
  logic [63:0]    dec_count_o;
  logic           halted_o;

  typedef struct packed {
    logic [63:0]    pc;
    decoded_instr_t cmd;
    logic           illegal;
  } obs_t;

  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;
  fetch_entry_t acc_q[$];
  obs_t         exp_log[$];
  obs_t         act_log[$];
  logic [63:0]  exp_count;
  obs_t         mon_a;
  obs_t         mon_e;
  fetch_entry_t mon_f;
  logic [31:0]  legal_pool [6] = '{32'h00208463, 32'h010000EF, 32'h00A00093,
                                   32'h123450B7, 32'hFE209EE3, 32'h00008067};

  decode_stage_ctrl #(
    .XLEN       (64),
    .FIFO_DEPTH (2)
  ) dut (
    .clk_i         (clk_i),
    .arst_i        (arst_i),
    .flush_i       (flush_i),
    .fetch_pc_i    (fetch_pc_i),
    .fetch_code_i  (fetch_code_i),
    .fetch_valid_i (fetch_valid_i),
    .fetch_ready_o (fetch_ready_o),
    .dec_cmd_o     (dec_cmd_o),
    .dec_pc_o      (dec_pc_o),
    .dec_illegal_o (dec_illegal_o),
    .dec_valid_o   (dec_valid_o),
    .dec_ready_i   (dec_ready_i),
    .dec_count_o   (dec_count_o),
    .halted_o      (halted_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference decode from the RISC-V instruction formats for the supported subset.
  function automatic decoded_instr_t model_decode(input logic [31:0] c);
    decoded_instr_t d;
    logic [6:0] op;
    logic [2:0] f3;
    d  = '0;
    op = c[6:0];
    f3 = c[14:12];
    if (op == 7'h37 || op == 7'h17) begin
      d.funct = (op == 7'h37) ? LUI : AUIPC;
      d.rd    = c[11:7];
      d.imm   = 64'(longint'($signed({c[31:12], 12'b0})));
    end else if (op == 7'h6F && c[11:7] <= 5'd1) begin
      d.funct = JAL;
      d.rd    = c[11:7];
      d.imm   = 64'(longint'($signed({c[31], c[19:12], c[20], c[30:21], 1'b0})));
    end else if ((op == 7'h67 || op == 7'h13) && f3 == 3'd0) begin
      d.funct = (op == 7'h67) ? JALR : ADDI;
      d.rd    = c[11:7];
      d.rs1   = c[19:15];
      d.imm   = 64'(longint'($signed(c[31:20])));
    end else if (op == 7'h63 && f3 != 3'd2 && f3 != 3'd3) begin
      case (f3)
        3'd0:    d.funct = BEQ;
        3'd1:    d.funct = BNE;
        3'd4:    d.funct = BLT;
        3'd5:    d.funct = BGE;
        3'd6:    d.funct = BLTU;
        default: d.funct = BGEU;
      endcase
      d.rs1 = c[19:15];
      d.rs2 = c[24:20];
      d.imm = 64'(longint'($signed({c[31], c[7], c[30:25], c[11:8], 1'b0})));
    end
    return d;
  endfunction

  // Scoreboard: accepted entries must come out in order, each exactly once; flush and reset drop them.
  always @(negedge clk_i) begin
    if (arst_i) begin
      acc_q.delete();
      exp_count = '0;
    end else if (flush_i) begin
      acc_q.delete();
    end else begin
      if (dec_valid_o && dec_ready_i) begin
        mon_a = '{pc: dec_pc_o, cmd: dec_cmd_o, illegal: dec_illegal_o};
        if (acc_q.size() > 0) begin
          mon_f = acc_q.pop_front();
          mon_e.pc      = mon_f.pc;
          mon_e.cmd     = model_decode(mon_f.code);
          mon_e.illegal = (mon_e.cmd.funct == INVALID);
        end else begin
          mon_e = '{pc: '1, cmd: '0, illegal: 1'b1};
        end
        act_log.push_back(mon_a);
        exp_log.push_back(mon_e);
        exp_count = exp_count + 64'd1;
      end
      if (fetch_valid_i && fetch_ready_o) acc_q.push_back('{pc: fetch_pc_i, code: fetch_code_i});
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    flush_i       = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_pc_i    = '0;
    fetch_code_i  = '0;
    dec_ready_i   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    arst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++;
    if (fetch_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b want=0", fetch_ready_o); end
    n_checks++;
    if (dec_valid_o !== 1'b0 || halted_o !== 1'b0 || dec_illegal_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got valid=%b halted=%b illegal=%b want 0/0/0", dec_valid_o, halted_o, dec_illegal_o);
    end
    n_checks++;
    if (dec_count_o !== 64'd0 || dec_pc_o !== 64'd0 || dec_cmd_o !== '0) begin
      n_fail++; $display("FAIL reset_data got count=%0d pc=%h cmd=%h want zeros", dec_count_o, dec_pc_o, dec_cmd_o);
    end
    arst_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (fetch_ready_o !== 1'b0) begin n_fail++; $display("FAIL release_ready_early got=%b want=0", fetch_ready_o); end
    cyc();
    @(negedge clk_i);
    n_checks++;
    if (fetch_ready_o !== 1'b1) begin n_fail++; $display("FAIL release_ready got=%b want=1", fetch_ready_o); end
    cyc();
  endtask

  task automatic test_basic();
    decoded_instr_t want;
    want       = '0;
    want.funct = BEQ;
    want.rs1   = 5'd1;
    want.rs2   = 5'd2;
    want.imm   = 64'd8;
    exp_log.delete(); act_log.delete();
    fetch_pc_i = 64'h1000; fetch_code_i = 32'h00208463; fetch_valid_i = 1'b1; dec_ready_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (fetch_ready_o !== 1'b1) begin n_fail++; $display("FAIL basic_ready got=%b want=1", fetch_ready_o); end
    cyc();
    fetch_valid_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_latency_early got=%b want=0", dec_valid_o); end
    cyc();
    @(negedge clk_i);
    n_checks++;
    if (dec_valid_o !== 1'b1 || dec_pc_o !== 64'h1000) begin
      n_fail++; $display("FAIL basic_out got valid=%b pc=%h want 1/1000", dec_valid_o, dec_pc_o);
    end
    n_checks++;
    if (dec_cmd_o !== want || dec_illegal_o !== 1'b0) begin
      n_fail++; $display("FAIL basic_cmd got=%h ill=%b want=%h ill=0", dec_cmd_o, dec_illegal_o, want);
    end
    cyc();
    @(negedge clk_i);
    n_checks++;
    if (dec_count_o !== 64'd1 || dec_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL basic_count got count=%0d valid=%b want 1/0", dec_count_o, dec_valid_o);
    end
    n_checks++;
    if (act_log.size() != 1) begin n_fail++; $display("FAIL basic_log_size got=%0d want=1", act_log.size()); end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [63:0] cnt0;
    int unsigned run;
    logic        broken;
    cnt0 = exp_count;
    exp_log.delete(); act_log.delete();
    dec_ready_i = 1'b1;
    for (int n = 0; n < 8; n++) begin
      fetch_pc_i = 64'h2000 + 64'(4 * n); fetch_code_i = 32'h010000EF; fetch_valid_i = 1'b1;
      @(negedge clk_i);
      n_checks++;
      if (fetch_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready n=%0d got=%b want=1", n, fetch_ready_o); end
      if (dec_valid_o) run++;
      cyc();
    end
    fetch_valid_i = 1'b0;
    broken = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (dec_valid_o) begin
        if (run == 0 || run >= 8) broken = 1'b1;
        run++;
      end
      cyc();
    end
    n_checks++;
    if (run != 8 || broken) begin n_fail++; $display("FAIL b2b_valid_run got=%0d broken=%b want=8", run, broken); end
    n_checks++;
    if (dec_count_o !== cnt0 + 64'd8) begin n_fail++; $display("FAIL b2b_count got=%0d want=%0d", dec_count_o, cnt0 + 64'd8); end
    n_checks++;
    if (act_log.size() != 8) begin n_fail++; $display("FAIL b2b_log_size got=%0d want=8", act_log.size()); end
    for (int i = 0; i < act_log.size(); i++) begin
      n_checks++;
      if (act_log[i] !== exp_log[i] || act_log[i].pc !== 64'h2000 + 64'(4 * i)) begin
        n_fail++; $display("FAIL b2b_entry[%0d] got=%h want=%h", i, act_log[i], exp_log[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int unsigned    accepted;
    logic [63:0]    snap_pc;
    decoded_instr_t snap_cmd;
    accepted = 0;
    snap_pc  = '0;
    snap_cmd = '0;
    exp_log.delete(); act_log.delete();
    dec_ready_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      fetch_pc_i    = 64'h3000 + 64'(4 * accepted);
      fetch_code_i  = legal_pool[$urandom_range(0, 5)];
      fetch_valid_i = 1'b1;
      @(negedge clk_i);
      if (fetch_ready_o) accepted++;
      if (c == 2) begin
        snap_pc  = dec_pc_o;
        snap_cmd = dec_cmd_o;
      end
      if (c >= 2) begin
        n_checks++;
        if (dec_valid_o !== 1'b1 || dec_pc_o !== snap_pc || dec_cmd_o !== snap_cmd || dec_pc_o !== 64'h3000) begin
          n_fail++; $display("FAIL bp_stable c=%0d got valid=%b pc=%h want 1/3000", c, dec_valid_o, dec_pc_o);
        end
      end
      cyc();
    end
    n_checks++;
    if (accepted != 3) begin n_fail++; $display("FAIL bp_accepted got=%0d want=3", accepted); end
    fetch_valid_i = 1'b0;
    dec_ready_i   = 1'b1;
    repeat (6) cyc();
    n_checks++;
    if (act_log.size() != 3) begin n_fail++; $display("FAIL bp_log_size got=%0d want=3", act_log.size()); end
    for (int i = 0; i < act_log.size(); i++) begin
      n_checks++;
      if (act_log[i] !== exp_log[i] || act_log[i].pc !== 64'h3000 + 64'(4 * i)) begin
        n_fail++; $display("FAIL bp_entry[%0d] got=%h want=%h", i, act_log[i], exp_log[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [63:0] cnt0;
    cnt0 = exp_count;
    exp_log.delete(); act_log.delete();
    dec_ready_i = 1'b0;
    fetch_valid_i = 1'b1;
    fetch_pc_i = 64'h4000; fetch_code_i = 32'hDEADBEEF;
    cyc();
    fetch_pc_i = 64'h4004; fetch_code_i = 32'h00A00093;
    cyc();
    fetch_pc_i = 64'h4008; fetch_code_i = 32'h00208463;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      n_checks++;
      if (halted_o !== 1'b1 || dec_illegal_o !== 1'b1 || fetch_ready_o !== 1'b0 ||
          dec_valid_o !== 1'b1 || dec_pc_o !== 64'h4000) begin
        n_fail++; $display("FAIL ill_halt c=%0d got halted=%b ill=%b ready=%b valid=%b pc=%h want 1/1/0/1/4000",
                           c, halted_o, dec_illegal_o, fetch_ready_o, dec_valid_o, dec_pc_o);
      end
      cyc();
    end
    fetch_valid_i = 1'b0;
    dec_ready_i   = 1'b1;
    cyc();
    @(negedge clk_i);
    n_checks++;
    if (dec_valid_o !== 1'b0 || halted_o !== 1'b1) begin
      n_fail++; $display("FAIL ill_consumed got valid=%b halted=%b want 0/1", dec_valid_o, halted_o);
    end
    cyc();
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (halted_o !== 1'b0 || dec_valid_o !== 1'b0 || dec_illegal_o !== 1'b0) begin
      n_fail++; $display("FAIL ill_flush got halted=%b valid=%b ill=%b want 0/0/0", halted_o, dec_valid_o, dec_illegal_o);
    end
    cyc();
    fetch_valid_i = 1'b1; fetch_pc_i = 64'h4010; fetch_code_i = 32'h123450B7;
    cyc();
    fetch_valid_i = 1'b0;
    repeat (3) cyc();
    n_checks++;
    if (act_log.size() != 2 || dec_count_o !== cnt0 + 64'd2) begin
      n_fail++; $display("FAIL ill_log got size=%0d count=%0d want 2/%0d", act_log.size(), dec_count_o, cnt0 + 64'd2);
    end
    n_checks++;
    if (act_log.size() > 0 && (act_log[0].illegal !== 1'b1 || act_log[0].cmd !== '0 || act_log[0] !== exp_log[0])) begin
      n_fail++; $display("FAIL ill_entry got=%h want=%h", act_log[0], exp_log[0]);
    end
    n_checks++;
    if (act_log.size() > 1 && (act_log[1] !== exp_log[1] || act_log[1].pc !== 64'h4010)) begin
      n_fail++; $display("FAIL ill_after_flush got=%h want=%h", act_log[1], exp_log[1]);
    end
  endtask

  task automatic test_flush_collision();
    logic [63:0] cnt0;
    logic        seen;
    cnt0 = exp_count;
    exp_log.delete(); act_log.delete();
    dec_ready_i = 1'b0; fetch_valid_i = 1'b1;
    fetch_pc_i = 64'h5000; fetch_code_i = 32'h00008067;
    cyc();
    fetch_pc_i = 64'h5004; fetch_code_i = 32'hFE209EE3;
    cyc();
    fetch_pc_i = 64'h5008; fetch_code_i = 32'h00A00093;
    flush_i = 1'b1; dec_ready_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (dec_valid_o !== 1'b1 || fetch_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL fc_setup got valid=%b ready=%b want 1/0", dec_valid_o, fetch_ready_o);
    end
    cyc();
    flush_i = 1'b0; fetch_valid_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      if (dec_valid_o) seen = 1'b1;
      cyc();
    end
    n_checks++;
    if (seen || dec_count_o !== cnt0) begin
      n_fail++; $display("FAIL fc_discard got stale=%b count=%0d want 0/%0d", seen, dec_count_o, cnt0);
    end
    n_checks++;
    if (act_log.size() != 0) begin n_fail++; $display("FAIL fc_log_size got=%0d want=0", act_log.size()); end
  endtask

  task automatic test_reset_midstream();
    logic seen;
    exp_log.delete(); act_log.delete();
    dec_ready_i = 1'b0; fetch_valid_i = 1'b1;
    fetch_pc_i = 64'h6000; fetch_code_i = 32'h00208463;
    cyc();
    fetch_pc_i = 64'h6004; fetch_code_i = 32'h010000EF;
    cyc();
    fetch_valid_i = 1'b0;
    n_checks++;
    if (dec_valid_o !== 1'b1 || dec_count_o === 64'd0) begin
      n_fail++; $display("FAIL rm_pre got valid=%b count=%0d want 1/nonzero", dec_valid_o, dec_count_o);
    end
    #2;
    arst_i = 1'b1;
    #1;
    n_checks++;
    if (dec_valid_o !== 1'b0 || dec_count_o !== 64'd0 || fetch_ready_o !== 1'b0 || halted_o !== 1'b0 ||
        dec_pc_o !== 64'd0 || dec_cmd_o !== '0 || dec_illegal_o !== 1'b0) begin
      n_fail++; $display("FAIL rm_async got valid=%b count=%0d ready=%b pc=%h want reset values",
                         dec_valid_o, dec_count_o, fetch_ready_o, dec_pc_o);
    end
    cyc();
    arst_i = 1'b0; dec_ready_i = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      if (dec_valid_o) seen = 1'b1;
      cyc();
    end
    n_checks++;
    if (seen || dec_count_o !== 64'd0 || act_log.size() != 0) begin
      n_fail++; $display("FAIL rm_stale got stale=%b count=%0d log=%0d want 0/0/0", seen, dec_count_o, act_log.size());
    end
  endtask

  task automatic test_random();
    exp_log.delete(); act_log.delete();
    for (int c = 0; c < 300; c++) begin
      fetch_valid_i = ($urandom_range(0, 3) != 0);
      fetch_pc_i    = {32'h0, $urandom} & 64'hFFFF_FFFC;
      fetch_code_i  = legal_pool[$urandom_range(0, 5)];
      dec_ready_i   = $urandom_range(0, 1) == 1;
      flush_i       = ($urandom_range(0, 39) == 0);
      cyc();
    end
    idle_inputs();
    dec_ready_i = 1'b1;
    repeat (6) cyc();
    n_checks++;
    if (act_log.size() < 50) begin n_fail++; $display("FAIL rnd_volume got=%0d want>=50", act_log.size()); end
    n_checks++;
    if (acc_q.size() != 0 || dec_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rnd_drain got pending=%0d valid=%b want 0/0", acc_q.size(), dec_valid_o);
    end
    n_checks++;
    if (dec_count_o !== exp_count) begin n_fail++; $display("FAIL rnd_count got=%0d want=%0d", dec_count_o, exp_count); end
    for (int i = 0; i < act_log.size(); i++) begin
      n_checks++;
      if (act_log[i] !== exp_log[i]) begin
        n_fail++; $display("FAIL rnd_entry[%0d] got=%h want=%h", i, act_log[i], exp_log[i]);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_flush_collision();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
